// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and bus-level ACK/NACK values.
// Used by the target here and by the I2C master blocks.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StRx,
        StRxAck,
        StTx,
        StTxAck
    } i2c_state_e;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizes raw SCL/SDA into clk and derives SCL edges plus START/STOP
// from the synchronized levels only.
module i2c_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_hist_q;
    logic                   sda_hist_q;
    logic                   scl_s;
    logic                   sda_s;

    // Reset to 1s so an idle bus produces no spurious edges.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q[0] <= scl_i;
            sda_sync_q[0] <= sda_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                scl_sync_q[i] <= scl_sync_q[i-1];
                sda_sync_q[i] <= sda_sync_q[i-1];
            end
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
        end
    end

    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign sda_o      = sda_s;
    assign scl_rise_o = scl_s & ~scl_hist_q;
    assign scl_fall_o = ~scl_s & scl_hist_q;
    assign start_o    = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_o     = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, byte receive with unconditional ACK and
// byte transmit fed through a tx_req/tx_data handshake.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       rw,
    output logic       stop_det
);

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;

    i2c_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk_i     (clk),
        .rst_i     (rst),
        .scl_i     (scl_in),
        .sda_i     (sda_in),
        .sda_o     (sda_s),
        .scl_rise_o(scl_rise),
        .scl_fall_o(scl_fall),
        .start_o   (start),
        .stop_o    (stop)
    );

    i2c_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       busy_q, busy_d;
    logic       rw_q, rw_d;
    logic       stop_det_q, stop_det_d;
    logic       sda_oe_q, sda_oe_d;
    logic       tx_req_c;
    logic [7:0] byte_in;

    assign byte_in = {shift_q[6:0], sda_s};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        busy_d     = busy_q;
        rw_d       = rw_q;
        stop_det_d = 1'b0;
        sda_oe_d   = sda_oe_q;
        tx_req_c   = 1'b0;

        if (stop) begin
            state_d    = StIdle;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            stop_det_d = 1'b1;
        end else if (start) begin
            state_d   = StAddr;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StAddr: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (byte_in[7:1] == SLAVE_ADDR) begin
                                rw_d    = byte_in[0];
                                busy_d  = 1'b1;
                                state_d = StAddrAck;
                            end else begin
                                state_d = StIdle;
                            end
                        end
                    end
                end
                // sda_oe doubles as the phase flag: the first fall starts the ACK
                // bit, the second fall ends it.
                StAddrAck: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = ~ACK;
                        end else if (!rw_q) begin
                            state_d   = StRx;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                        end else begin
                            state_d   = StTx;
                            tx_req_c  = 1'b1;
                            shift_d   = tx_data;
                            sda_oe_d  = ~tx_data[7];
                            bit_cnt_d = 3'd0;
                        end
                    end
                end
                StRx: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = byte_in;
                            rx_valid_d = 1'b1;
                            state_d    = StRxAck;
                        end
                    end
                end
                StRxAck: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = ~ACK;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = StRx;
                        end
                    end
                end
                StTx: begin
                    if (scl_fall) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d = 1'b0;
                            state_d  = StTxAck;
                        end else begin
                            shift_d  = {shift_q[6:0], shift_q[7]};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                // Entered on a fall, so the only fall seen here follows the ACK rise.
                StTxAck: begin
                    if (scl_rise && sda_s == NACK) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end else if (scl_fall) begin
                        state_d   = StTx;
                        tx_req_c  = 1'b1;
                        shift_d   = tx_data;
                        sda_oe_d  = ~tx_data[7];
                        bit_cnt_d = 3'd0;
                    end
                end
                default: begin
                    state_d  = StIdle;
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
            stop_det_q <= 1'b0;
            sda_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
            stop_det_q <= stop_det_d;
            sda_oe_q   <= sda_oe_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign tx_req   = tx_req_c & ~rst;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign rw       = rw_q;
    assign stop_det = stop_det_q;

endmodule
